bias_loader: RTL
================

// Module: bias_loader
// PURPOSE
//  Requester end of the controller's load-grant handshake for bias: raises load_bias_req, waits for load_bias_granted,
//  then fetches one tile (SIZE channels) of 32-bit bias words over the shared ICB read port. Holds them as a vector
//  for the accumulator with bias_valid. Sits between mma_controller (grant/icb_sel) and the accumulator.
// PARAMETERS
//  SIZE       16  channels per tile (bias words per fetch)
//  BUS_WIDTH  32  ICB address/data width; one bias word per beat
//  REG_WIDTH  32  width of config registers
// PORTS
//  clk                 in   1               clock
//  rst                 in   1               synchronous reset, active-high
//  init_cfg_bias       in   1               single-cycle config strobe
//  cfg_bias_base       in   REG_WIDTH       byte address of channel 0 bias, word aligned
//  cfg_oc_total        in   REG_WIDTH       total output channels (>=1)
//  need_bias           in   1               0: skip fetch, supply zeros
//  bias_fetch          in   1               pulse: fetch next tile
//  load_bias_req       out  1               bus request to controller
//  load_bias_granted   in   1               grant, held while bus owned
//  icb_cmd_valid       out  1               ICB cmd valid
//  icb_cmd_ready       in   1               ICB cmd ready
//  icb_cmd_addr        out  BUS_WIDTH       ICB cmd address
//  icb_cmd_read        out  1               constant 1
//  icb_rsp_valid       in   1               ICB rsp valid
//  icb_rsp_ready       out  1               constant 1
//  icb_rsp_rdata       in   BUS_WIDTH       ICB rsp data
//  icb_rsp_err         in   1               ICB rsp error
//  bias_vec            out  SIZE*BUS_WIDTH  bias words, channel i at [i*32 +: 32]
//  bias_valid          out  1               bias_vec valid; held until bias_consume
//  bias_consume        in   1               pulse: accumulator finished with bias_vec
//  bias_err            out  1               sticky ICB error flag
// BEHAVIOUR
//  Reset: all outputs 0 except icb_cmd_read=1 and icb_rsp_ready=1. Registers cleared: FSM=IDLE, ch_ptr=0, counters=0.
//  Reset mid-fetch drops load_bias_req immediately. Responses arriving afterwards are accepted and discarded.
//  Config: init_cfg_bias is taken in IDLE only; it latches base/oc_total and clears ch_ptr and bias_err. Ignored elsewhere.
//  Tile length n = min(SIZE, oc_total - ch_ptr). Lanes n..SIZE-1 are zero-filled.
//  FSM:
//   IDLE   : bias_fetch & need_bias -> REQ. bias_fetch & !need_bias -> VALID next cycle with bias_vec=0.
//   REQ    : load_bias_req=1; granted -> CMD.
//   CMD    : icb_cmd_valid=1, addr = base + 4*(ch_ptr+cmd_cnt); cmd_cnt++ on valid&ready; cmd_cnt==n-1 handshake -> RSP.
//   RSP    : wait until rsp_cnt==n; then drop load_bias_req, ch_ptr += n (wraps to 0 when == oc_total) -> VALID.
//   VALID  : bias_valid=1; bias_consume -> IDLE (bias_valid low next cycle).
//  Responses are accepted in CMD and RSP. Word k is stored to lane rsp_cnt (in-order ICB); rsp_cnt++.
//  load_bias_req stays high from REQ until the last response; it is never dropped while a response is outstanding.
//  Granted deasserting while in CMD: icb_cmd_valid deasserts, request stays up, resume when regranted.
//  bias_fetch outside IDLE is ignored. bias_consume and bias_fetch in the same VALID cycle: consume only.
//  Latency: fetch-to-valid >= 3 + n cycles at zero-wait ICB and an immediate grant.
// CONFIGURATION
//  BIAS_LOADER_ERR_CHK_EN defined: icb_rsp_err on a response sets bias_err (sticky) and stores 0 in that lane.
//  BIAS_LOADER_ERR_CHK_EN undefined: icb_rsp_err is ignored, rdata is stored as-is, bias_err is tied to 0.
// TESTING
//  1 cfg base=0x1000,oc=16; fetch; grant after 2 cyc -> 16 cmds addr 0x1000..0x103C, bias_vec matches mem, req drops.
//  2 oc=20, two fetch/consume cycles -> 2nd tile n=4 at 0x1040.., lanes 4..15=0; 3rd fetch wraps to 0x1000.
//  3 need_bias=0, fetch -> no ICB traffic, req never rises, bias_valid=1 next cycle with bias_vec all zero.
//  4 icb_cmd_ready random 50% plus grant dropped for 3 cyc mid-CMD -> no cmd while ungranted, data still exact.
//  5 ERR_CHK_EN on: rsp_err on beat 5 -> bias_err=1, lane5=0. Off: lane5=rdata, bias_err=0.
//  6 rst asserted in RSP with 3 rsp pending -> outputs at reset values next cycle; late rsps absorbed; fresh fetch ok.

Source files
------------

// File: rtl/bias_loader.sv
// Bias tile fetcher: request/grant handshake with the controller, then SIZE-word burst over the ICB read port.
// Optional BIAS_LOADER_ERR_CHK_EN: response errors zero the lane and set a sticky bias_err flag.
`timescale 1ns/1ps
module bias_loader #(
    parameter int SIZE      = 16,
    parameter int BUS_WIDTH = 32,
    parameter int REG_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_cfg_bias,
    input  logic [REG_WIDTH-1:0]      cfg_bias_base,
    input  logic [REG_WIDTH-1:0]      cfg_oc_total,
    input  logic                      need_bias,
    input  logic                      bias_fetch,
    output logic                      load_bias_req,
    input  logic                      load_bias_granted,
    output logic                      icb_cmd_valid,
    input  logic                      icb_cmd_ready,
    output logic [BUS_WIDTH-1:0]      icb_cmd_addr,
    output logic                      icb_cmd_read,
    input  logic                      icb_rsp_valid,
    output logic                      icb_rsp_ready,
    input  logic [BUS_WIDTH-1:0]      icb_rsp_rdata,
    input  logic                      icb_rsp_err,
    output logic [SIZE*BUS_WIDTH-1:0] bias_vec,
    output logic                      bias_valid,
    input  logic                      bias_consume,
    output logic                      bias_err
);
    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_CMD, S_RSP, S_VALID} state_t;

    state_t                    r_state;
    logic [REG_WIDTH-1:0]      r_base;
    logic [REG_WIDTH-1:0]      r_oc;
    logic [REG_WIDTH-1:0]      r_ch_ptr;
    logic [CW-1:0]             r_n;
    logic [CW-1:0]             r_cmd_cnt;
    logic [CW-1:0]             r_rsp_cnt;
    logic                      r_req;
    logic                      r_valid;
    logic                      r_err;
    logic [SIZE*BUS_WIDTH-1:0] r_vec;

    logic [REG_WIDTH-1:0]      w_remain;
    logic [CW-1:0]             w_n;
    logic                      w_cmd_valid;
    logic                      w_cmd_hs;
    logic [REG_WIDTH-1:0]      w_addr;
    logic                      w_rsp_take;
    logic [REG_WIDTH-1:0]      w_ptr_next;
    logic [BUS_WIDTH-1:0]      w_rsp_word;

    // Tile length is clipped to the channels left before the end of oc_total
    assign w_remain    = r_oc - r_ch_ptr;
    assign w_n         = (w_remain >= REG_WIDTH'(SIZE)) ? CW'(SIZE) : CW'(w_remain);
    assign w_cmd_valid = (r_state == S_CMD) && load_bias_granted;
    assign w_cmd_hs    = w_cmd_valid && icb_cmd_ready;
    assign w_addr      = r_base + ((r_ch_ptr + REG_WIDTH'(r_cmd_cnt)) << 2);
    assign w_rsp_take  = icb_rsp_valid && ((r_state == S_CMD) || (r_state == S_RSP)) && (r_rsp_cnt < r_n);
    assign w_ptr_next  = r_ch_ptr + REG_WIDTH'(r_n);

`ifdef BIAS_LOADER_ERR_CHK_EN
    assign w_rsp_word = icb_rsp_err ? '0 : icb_rsp_rdata;
`else
    logic w_unused_rsp_err;
    assign w_unused_rsp_err = icb_rsp_err;
    assign w_rsp_word       = icb_rsp_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_oc      <= '0;
            r_ch_ptr  <= '0;
            r_n       <= '0;
            r_cmd_cnt <= '0;
            r_rsp_cnt <= '0;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_vec     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init_cfg_bias) begin
                        r_base   <= cfg_bias_base;
                        r_oc     <= cfg_oc_total;
                        r_ch_ptr <= '0;
                        r_err    <= 1'b0;
                    end else if (bias_fetch) begin
                        r_vec     <= '0;
                        r_n       <= w_n;
                        r_cmd_cnt <= '0;
                        r_rsp_cnt <= '0;
                        if (need_bias) begin
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_valid <= 1'b1;
                            r_state <= S_VALID;
                        end
                    end
                end
                S_REQ: begin
                    if (load_bias_granted) r_state <= S_CMD;
                end
                S_CMD: begin
                    if (w_cmd_hs) begin
                        r_cmd_cnt <= r_cmd_cnt + CW'(1);
                        if (r_cmd_cnt == r_n - CW'(1)) r_state <= S_RSP;
                    end
                end
                S_RSP: begin
                    // Bus is released only once every issued read has returned
                    if (r_rsp_cnt == r_n) begin
                        r_req    <= 1'b0;
                        r_ch_ptr <= (w_ptr_next == r_oc) ? '0 : w_ptr_next;
                        r_valid  <= 1'b1;
                        r_state  <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (bias_consume) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_rsp_take) begin
                r_vec[int'(r_rsp_cnt)*BUS_WIDTH +: BUS_WIDTH] <= w_rsp_word;
                r_rsp_cnt <= r_rsp_cnt + CW'(1);
`ifdef BIAS_LOADER_ERR_CHK_EN
                if (icb_rsp_err) r_err <= 1'b1;
`endif
            end
        end
    end

    assign load_bias_req = r_req;
    assign icb_cmd_valid = w_cmd_valid;
    assign icb_cmd_addr  = BUS_WIDTH'(w_addr);
    assign icb_cmd_read  = 1'b1;
    assign icb_rsp_ready = 1'b1;
    assign bias_vec      = r_vec;
    assign bias_valid    = r_valid;
    assign bias_err      = r_err;
endmodule
